// File: rtl/divisor_sequencial.sv
// Sequential restoring divider, unsigned, one quotient bit per clock (MSB first).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   inicio          - start request, accepted only while idle
//   A, B            - dividend / divisor, captured when a start is accepted
//   Quociente, Resto- registered quotient / remainder of last completed operation
//   ocupado         - high while an operation is in progress
//   pronto          - one-cycle pulse when results have just been updated
//   div_zero        - set when the last completed operation had B == 0
module divisor_sequencial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quociente,
    output logic [WIDTH-1:0] Resto,
    output logic             ocupado,
    output logic             pronto,
    output logic             div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] quo_out_q;
    logic [WIDTH-1:0] res_out_q;
    logic             dz_out_q;
    logic             ocupado_q;
    logic             pronto_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;

        // Partial remainder never has its MSB set before the shift, so dropping it is lossless
        shifted = {1'b0, rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        case (state_q)
            OCIOSO: begin
                if (inicio) begin
                    dvd_d = A;
                    dvs_d = B;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (B == '0) begin
                        dz_d    = 1'b1;
                        state_d = FIM;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = CALCULA;
                    end
                end
            end
            CALCULA: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                // trial MSB is the borrow: restore on borrow
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIM;
                end
            end
            FIM: begin
                state_d = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase
    end

    // State, datapath and output registers; outputs load on entry to FIM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCIOSO;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
            quo_out_q <= '0;
            res_out_q <= '0;
            dz_out_q  <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            dz_q      <= dz_d;
            ocupado_q <= (state_d != OCIOSO);
            pronto_q  <= (state_d == FIM);
            if (state_d == FIM) begin
                quo_out_q <= quo_d;
                res_out_q <= rem_d;
                dz_out_q  <= dz_d;
            end
        end
    end

    assign Quociente = quo_out_q;
    assign Resto     = res_out_q;
    assign div_zero  = dz_out_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed bench for divisor_sequencial: WIDTH=4 and WIDTH=8 instances.
// Latency is counted in edges after the edge at which inicio is driven.
module tb_divisor_sequencial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inicio4, inicio8;
    logic [3:0] a4, b4, q4, r4;
    logic [7:0] a8, b8, q8, r8;
    logic       oc4, pr4, dz4, oc8, pr8, dz8;

    int total = 0;
    int bad   = 0;
    int lat;
    int npr;

    always #5 clk = ~clk;

    divisor_sequencial #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio4), .A(a4), .B(b4),
        .Quociente(q4), .Resto(r4), .ocupado(oc4), .pronto(pr4), .div_zero(dz4)
    );

    divisor_sequencial #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio8), .A(a8), .B(b8),
        .Quociente(q8), .Resto(r8), .ocupado(oc8), .pronto(pr8), .div_zero(dz8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse a start on the 4-bit unit and return edges until pronto (0 on timeout)
    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int l);
        int n;
        a4 = a; b4 = b; inicio4 = 1'b1;
        n = 0; l = 0;
        while (l == 0 && n < 40) begin
            step();
            n++;
            if (n == 1) inicio4 = 1'b0;
            if (pr4) l = n;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int l);
        int n;
        a8 = a; b8 = b; inicio8 = 1'b1;
        n = 0; l = 0;
        while (l == 0 && n < 40) begin
            step();
            n++;
            if (n == 1) inicio8 = 1'b0;
            if (pr8) l = n;
        end
    endtask

    initial begin
        rst_n = 1'b1; inicio4 = 1'b0; inicio8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        #2 rst_n = 1'b0;
        step(); step();
        chk("rst_q", 32'(q4), 0);
        chk("rst_r", 32'(r4), 0);
        chk("rst_ocupado", 32'(oc4), 0);
        chk("rst_pronto", 32'(pr4), 0);
        chk("rst_dz", 32'(dz4), 0);
        rst_n = 1'b1;
        step();

        // 13/3 with ocupado the cycle after the start edge
        a4 = 4'd13; b4 = 4'd3; inicio4 = 1'b1;
        step(); inicio4 = 1'b0;
        chk("13_3_ocupado", 32'(oc4), 1);
        step(); step(); step();
        chk("13_3_no_early_pronto", 32'(pr4), 0);
        step();
        chk("13_3_pronto_edge5", 32'(pr4), 1);
        chk("13_3_q", 32'(q4), 4);
        chk("13_3_r", 32'(r4), 1);
        chk("13_3_dz", 32'(dz4), 0);
        step();
        chk("13_3_pronto_one_cycle", 32'(pr4), 0);
        chk("13_3_ocupado_drop", 32'(oc4), 0);
        chk("13_3_hold_q", 32'(q4), 4);

        // Divide by zero, then a normal operation clears div_zero
        run4(4'd7, 4'd0, lat);
        chk("7_0_lat", 32'(lat), 1);
        chk("7_0_q", 32'(q4), 0);
        chk("7_0_r", 32'(r4), 0);
        chk("7_0_dz", 32'(dz4), 1);
        step();
        run4(4'd15, 4'd1, lat);
        chk("15_1_lat", 32'(lat), 5);
        chk("15_1_q", 32'(q4), 15);
        chk("15_1_r", 32'(r4), 0);
        chk("15_1_dz", 32'(dz4), 0);
        step();

        run4(4'd3, 4'd7, lat);
        chk("3_7_q", 32'(q4), 0);
        chk("3_7_r", 32'(r4), 3);
        step();

        // All 4-bit pairs against the division identity
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(a[3:0], b[3:0], lat);
                chk("exh_lat", 32'(lat), (b == 0) ? 32'd1 : 32'd5);
                if (b == 0) begin
                    chk("exh_z_q", 32'(q4), 0);
                    chk("exh_z_r", 32'(r4), 0);
                    chk("exh_z_dz", 32'(dz4), 1);
                end else begin
                    chk("exh_identity", 32'(int'(q4) * b + int'(r4)), 32'(a));
                    chk("exh_r_lt_b", 32'(int'(r4) < b), 1);
                    chk("exh_dz", 32'(dz4), 0);
                end
                step();
            end
        end

        // 8-bit instance
        run8(8'd200, 8'd7, lat);
        chk("200_7_lat", 32'(lat), 9);
        chk("200_7_q", 32'(q8), 28);
        chk("200_7_r", 32'(r8), 4);
        step();
        run8(8'd255, 8'd255, lat);
        chk("255_255_q", 32'(q8), 1);
        chk("255_255_r", 32'(r8), 0);
        step();

        // Restart attempt during CALCULA is ignored
        a4 = 4'd13; b4 = 4'd3; inicio4 = 1'b1;
        npr = 0; lat = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 1) inicio4 = 1'b0;
            if (n == 2) begin a4 = 4'd9; b4 = 4'd2; inicio4 = 1'b1; end
            if (n == 3) inicio4 = 1'b0;
            if (pr4) begin npr++; if (lat == 0) lat = n; end
        end
        chk("ignore_pronto_count", 32'(npr), 1);
        chk("ignore_lat", 32'(lat), 5);
        chk("ignore_q", 32'(q4), 4);
        chk("ignore_r", 32'(r4), 1);

        // Asynchronous reset mid-CALCULA aborts without pronto
        run4(4'd15, 4'd2, lat);
        chk("pre_abort_q", 32'(q4), 7);
        step();
        a4 = 4'd13; b4 = 4'd3; inicio4 = 1'b1;
        step(); inicio4 = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("abort_q", 32'(q4), 0);
        chk("abort_r", 32'(r4), 0);
        chk("abort_ocupado", 32'(oc4), 0);
        chk("abort_pronto", 32'(pr4), 0);
        npr = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (pr4) npr++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            if (pr4) npr++;
        end
        chk("abort_no_pronto", 32'(npr), 0);
        run4(4'd9, 4'd2, lat);
        chk("after_abort_lat", 32'(lat), 5);
        chk("after_abort_q", 32'(q4), 4);
        chk("after_abort_r", 32'(r4), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
